sqrt_eval_ctrl: RTL and testbench
=================================

Name: sqrt_eval_ctrl

Overview:
- Sequencer for the piecewise-linear square-root stage of the Box-Muller AWGN datapath: computes f = sqrt(e) for the log-stage output e.
- Range-reduces e to x in [1,4), selects the [1,2) or [2,4) coefficient table, drives the shared 6-bit table address, and performs the c1*x_b + c0 multiply-add.
- Returns mantissa, exponent and zero flag over valid/ready handshakes; sits between the ln unit and the sin/cos multiply stage.

Parameters:
- IN_W, 31, width of input e (unsigned fixed point).
- IN_FRAC, 24, fractional bits of e.
- C1_SHIFT, 18, right shift applied to c1*x_b before adding c0.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  e is valid.
- in_ready  output  1  block can accept e.
- e_in  input  IN_W  operand.
- rom_addr  output  6  address to both coefficient tables.
- rom_sel  output  1  0 = [1,2) table, 1 = [2,4) table.
- rom1_data  input  32  [1,2) table word: c1 = [31:20], c0 = [19:0].
- rom2_data  input  32  [2,4) table word, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sqrt_mant  output  20  sqrt of x, same format as c0.
- sqrt_exp  output  5  signed m; sqrt(e) = sqrt_mant * 2^m.
- sqrt_zero  output  1  input was 0.

Behaviour:
- Reset, asynchronous, active-low: FSM goes to IDLE; in_ready=1; out_valid, rom_addr, rom_sel, sqrt_mant, sqrt_exp and sqrt_zero all 0; internal registers cleared. Reset mid-operation discards the in-flight operand with no output.
- FSM states: IDLE, NORM, LOOK, MAC, DONE. in_ready=1 only in IDLE.
- IDLE:
  - On in_valid, latch e_in into e_r and go to NORM.
- NORM:
  - If e_r==0: mant=0, exp=0, zero=1; go to DONE.
  - Else, with p = MSB index of e_r (0..30):
    - xn_r = e_r << (30-p), so bit 30 is 1.
    - k = p - IN_FRAC (-24..6).
    - rom_sel_r = k[0] (odd k selects table 2).
    - m_r = floor(k/2), an arithmetic shift (-12..3).
    - zero=0; go to LOOK.
- LOOK:
  - rom_addr = xn_r[29:24] and rom_sel = rom_sel_r, both registered so they are stable for the whole cycle.
  - Tables are combinational. Capture c1_r/c0_r from rom2_data if rom_sel_r, else from rom1_data.
  - xb_r = xn_r[23:6] (18 bits); go to MAC.
- MAC:
  - prod = c1_r * xb_r (30-bit unsigned).
  - sum = c0_r + (prod >> C1_SHIFT), computed at 21 bits.
  - sqrt_mant = sum saturated to 0xFFFFF; sqrt_exp = m_r; go to DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. out_valid drops and in_ready rises the next cycle; there is no same-cycle bypass.
- Latency and throughput:
  - Nonzero e: out_valid 4 cycles after the accept edge.
  - Zero e: 2 cycles after the accept edge.
  - One operation in flight; throughput is 1 per 5 cycles with out_ready held high.
- Edge cases:
  - in_valid while busy is ignored (in_ready=0); the upstream holds its data.
  - rom_addr and rom_sel keep their last value outside LOOK.
  - sqrt_mant, sqrt_exp and sqrt_zero keep their last value after handshake completion.

Test Plan:
- e=0x1000000 (1.0); ROM1[0] c1=0, c0=0x12345 -> rom_sel=0, rom_addr=0, mant=0x12345, exp=0, zero=0, out_valid 4 cycles after accept.
- e=0x2000000 (2.0) -> rom_sel=1, addr=0, exp=0. e=0x4000000 -> rom_sel=0, exp=1. e=0x1 -> rom_sel=0, addr=0, exp=-12 (5'b10100). e=0x1800000 (1.5) -> addr=32.
- e=0x1020000 (xn bit 23 set, xb=0x20000); c1=0x010, c0=0x00100 -> mant=0x00108. Same e with c1=0xFFF, c0=0xFFFFF -> mant=0xFFFFF (saturated).
- e=0 -> out_valid 2 cycles after accept, mant=0, exp=0, zero=1; no ROM capture.
- Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted. Release out_ready -> second operand accepted on the following cycle.
- Assert rst_n=0 during MAC -> all outputs 0 immediately. After release: in_ready=1, no stale out_valid, next operation correct.

Source files
------------

// File: rtl/sqrt_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_eval_ctrl
// Description : Piecewise-linear sqrt(e) sequencer for the Box-Muller AWGN path:
//               range reduction, coefficient table lookup and c1*x+c0 evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_eval_ctrl #(
    parameter int IN_W     = 31,
    parameter int IN_FRAC  = 24,
    parameter int C1_SHIFT = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] e_in,
    output logic [5:0]      rom_addr,
    output logic            rom_sel,
    input  logic [31:0]     rom1_data,
    input  logic [31:0]     rom2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [19:0]     sqrt_mant,
    output logic [4:0]      sqrt_exp,
    output logic            sqrt_zero
);

    localparam int c_P_W  = $clog2(IN_W);
    localparam int c_XN_W = IN_W - 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_LOOK = 3'd2,
        S_MAC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [IN_W-1:0]   r_e;
    logic [17:0]       r_xn;
    logic [17:0]       r_xb;
    logic [11:0]       r_c1;
    logic [19:0]       r_c0;
    logic [4:0]        r_m;
    logic [5:0]        r_rom_addr;
    logic              r_rom_sel;
    logic [19:0]       r_mant;
    logic [4:0]        r_exp;
    logic              r_zero;

    logic [c_P_W-1:0]  w_p;
    logic [c_P_W-1:0]  w_sh;
    logic signed [7:0] w_k;
    logic [4:0]        w_m;
    logic [c_XN_W-1:0] w_xn;
    logic [31:0]       w_word;
    logic [29:0]       w_prod;
    logic [20:0]       w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_NORM;
            S_NORM:  w_next = (r_e == '0) ? S_DONE : S_LOOK;
            S_LOOK:  w_next = S_MAC;
            S_MAC:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Leading-one position; the last hit wins so the MSB is reported.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (r_e[i]) w_p = c_P_W'(i);
        end
    end

    always_comb begin
        w_sh = c_P_W'(IN_W - 1) - w_p;
        w_k  = 8'(w_p) - 8'(IN_FRAC);
        w_m  = 5'(w_k >>> 1);
        // Drop the implied leading one and the six LSBs below the x_b field.
        w_xn = c_XN_W'((r_e << w_sh) >> 6);
    end

    always_comb begin
        w_word = r_rom_sel ? rom2_data : rom1_data;
        w_prod = 30'(r_c1) * 30'(r_xb);
        w_sum  = {1'b0, r_c0} + 21'(w_prod >> C1_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e        <= '0;
            r_xn       <= '0;
            r_xb       <= '0;
            r_c1       <= '0;
            r_c0       <= '0;
            r_m        <= '0;
            r_rom_addr <= '0;
            r_rom_sel  <= 1'b0;
            r_mant     <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) r_e <= e_in;
                end
                S_NORM: begin
                    if (r_e == '0) begin
                        r_mant <= '0;
                        r_exp  <= '0;
                        r_zero <= 1'b1;
                    end else begin
                        // Address/select registered here so they are steady throughout LOOK.
                        r_rom_addr <= w_xn[c_XN_W-1 -: 6];
                        r_xn       <= w_xn[17:0];
                        r_rom_sel  <= w_k[0];
                        r_m        <= w_m;
                        r_zero     <= 1'b0;
                    end
                end
                S_LOOK: begin
                    r_c1 <= w_word[31:20];
                    r_c0 <= w_word[19:0];
                    r_xb <= r_xn;
                end
                S_MAC: begin
                    r_mant <= w_sum[20] ? 20'hFFFFF : w_sum[19:0];
                    r_exp  <= r_m;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign rom_addr  = r_rom_addr;
    assign rom_sel   = r_rom_sel;
    assign sqrt_mant = r_mant;
    assign sqrt_exp  = r_exp;
    assign sqrt_zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_eval_ctrl
// Description : Directed self-checking bench for sqrt_eval_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] e_in;
    logic [5:0]  rom_addr;
    logic        rom_sel;
    logic [31:0] rom1_data;
    logic [31:0] rom2_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] sqrt_mant;
    logic [4:0]  sqrt_exp;
    logic        sqrt_zero;

    logic [31:0] rom1 [64];
    logic [31:0] rom2 [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom1_data = rom1[rom_addr];
    assign rom2_data = rom2[rom_addr];

    sqrt_eval_ctrl #(.IN_W(31), .IN_FRAC(24), .C1_SHIFT(18)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .rom_addr  (rom_addr),
        .rom_sel   (rom_sel),
        .rom1_data (rom1_data),
        .rom2_data (rom2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sqrt_mant (sqrt_mant),
        .sqrt_exp  (sqrt_exp),
        .sqrt_zero (sqrt_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present e, then count edges (accept edge = 1) until out_valid is seen.
    task automatic start_op(input logic [30:0] e, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        e_in     = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_check(input string tag, input logic [30:0] e, input int elat,
                             input logic [19:0] emant, input logic [4:0] eexp,
                             input logic ezero, input logic esel, input logic [5:0] eaddr);
        int lat;
        start_op(e, lat);
        $display("op %s e=0x%0h", tag, e);
        chk("lat",  lat,                   elat);
        chk("mant", {12'd0, sqrt_mant},    {12'd0, emant});
        chk("exp",  {27'd0, sqrt_exp},     {27'd0, eexp});
        chk("zero", {31'd0, sqrt_zero},    {31'd0, ezero});
        chk("sel",  {31'd0, rom_sel},      {31'd0, esel});
        chk("addr", {26'd0, rom_addr},     {26'd0, eaddr});
        finish_op();
    endtask

    initial begin
        int lat;
        logic [19:0] held_mant;

        for (int i = 0; i < 64; i++) begin
            rom1[i] = 32'd0;
            rom2[i] = 32'd0;
        end
        rom1[0]  = {12'h000, 20'h12345};
        rom2[0]  = {12'h000, 20'h0ABCD};
        rom1[32] = {12'h000, 20'h2AAAA};
        rom1[63] = {12'h100, 20'h10000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        e_in      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mant",      {12'd0, sqrt_mant}, 32'd0);
        chk("rst_addr",      {26'd0, rom_addr},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_check("one",      31'h1000000, 4, 20'h12345, 5'd0,  1'b0, 1'b0, 6'd0);
        run_check("two",      31'h2000000, 4, 20'h0ABCD, 5'd0,  1'b0, 1'b1, 6'd0);
        run_check("four",     31'h4000000, 4, 20'h12345, 5'd1,  1'b0, 1'b0, 6'd0);
        run_check("lsb",      31'h0000001, 4, 20'h12345, 5'h14, 1'b0, 1'b0, 6'd0);
        run_check("bit1",     31'h0000002, 4, 20'h0ABCD, 5'h14, 1'b0, 1'b1, 6'd0);
        run_check("max",      31'h7FFFFFFF, 4, 20'h100FF, 5'd3, 1'b0, 1'b0, 6'd63);

        rom1[0] = {12'h010, 20'h00100};
        run_check("mac",      31'h1020000, 4, 20'h00108, 5'd0,  1'b0, 1'b0, 6'd0);
        rom1[0] = {12'hFFF, 20'hFFFFF};
        run_check("sat",      31'h1020000, 4, 20'hFFFFF, 5'd0,  1'b0, 1'b0, 6'd0);
        rom1[0] = {12'h000, 20'h12345};

        run_check("onehalf",  31'h1800000, 4, 20'h2AAAA, 5'd0,  1'b0, 1'b0, 6'd32);
        // Zero bypasses lookup, so address/select keep the previous values.
        run_check("zero",     31'h0000000, 2, 20'h00000, 5'd0,  1'b1, 1'b0, 6'd32);
        run_check("after0",   31'h1000000, 4, 20'h12345, 5'd0,  1'b0, 1'b0, 6'd0);

        // Back-pressure: hold the result, offer a second operand meanwhile.
        @(negedge clk);
        out_ready = 1'b0;
        start_op(31'h1000000, lat);
        chk("bp_lat", lat, 4);
        held_mant = sqrt_mant;
        chk("bp_mant", {12'd0, held_mant}, {12'd0, 20'h12345});
        @(negedge clk);
        in_valid = 1'b1;
        e_in     = 31'h4000000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready},  32'd0);
            chk("bp_hold",  {12'd0, sqrt_mant}, {12'd0, 20'h12345});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp2_lat",  lat, 4);
        chk("bp2_mant", {12'd0, sqrt_mant}, {12'd0, 20'h12345});
        chk("bp2_exp",  {27'd0, sqrt_exp},  32'd1);
        finish_op();

        // Reset while in MAC (third edge after accept).
        @(negedge clk);
        in_valid = 1'b1;
        e_in     = 31'h1800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready},  32'd1);
        chk("mrst_addr",  {26'd0, rom_addr},  32'd0);
        chk("mrst_sel",   {31'd0, rom_sel},   32'd0);
        chk("mrst_mant",  {12'd0, sqrt_mant}, 32'd0);
        chk("mrst_exp",   {27'd0, sqrt_exp},  32'd0);
        chk("mrst_zero",  {31'd0, sqrt_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        run_check("post_rst", 31'h2000000, 4, 20'h0ABCD, 5'd0, 1'b0, 1'b1, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
